// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the ALU-system datapath.
// The sequencer is the master; the datapath returns IR contents and ALU flags.
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  ALUFlags;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_CS;
    logic        Mem_WR;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [2:0]  T;

    modport master (
        input  IROut, ALUFlags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_CS, Mem_WR,
               MuxASel, MuxBSel, MuxCSel, T
    );

    modport slave (
        output IROut, ALUFlags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_CS, Mem_WR,
               MuxASel, MuxBSel, MuxCSel, T
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: two-cycle byte fetch, decode, and one or two
// execute steps driving every datapath control input.
module control_sequencer (
    input  logic                  Clock,
    input  logic                  Reset,
    control_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_T0   = 3'b000,
        S_T1   = 3'b001,
        S_T2   = 3'b010,
        S_T3   = 3'b011,
        S_HALT = 3'b111
    } state_t;

    state_t      r_state;
    logic [5:0]  w_opcode;
    logic [1:0]  w_rx;
    logic [1:0]  w_ry;
    logic [3:0]  w_rx_onehot;
    logic        w_zero;
    logic        w_take_branch;
    logic        w_unused;

    assign w_opcode    = bus.IROut[15:10];
    assign w_rx        = bus.IROut[9:8];
    assign w_ry        = bus.IROut[7:6];
    assign w_rx_onehot = 4'b1000 >> w_rx;
    assign w_zero      = bus.ALUFlags[3];
    assign w_unused    = ^{bus.IROut[5:0], bus.ALUFlags[2:0]};

    assign w_take_branch = (w_opcode == 6'h01) ||
                           (w_opcode == 6'h02 &&  w_zero) ||
                           (w_opcode == 6'h03 && !w_zero);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_T0;
        end else begin
            case (r_state)
                S_T0:   r_state <= S_T1;
                S_T1:   r_state <= S_T2;
                S_T2: begin
                    case (w_opcode)
                        6'h09, 6'h0A: r_state <= S_T3;
                        6'h3F:        r_state <= S_HALT;
                        default:      r_state <= S_T0;
                    endcase
                end
                S_T3:   r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_T0;
            endcase
        end
    end

    // Reset overrides the decode so no datapath write can leak out of an abandoned instruction.
    always_comb begin
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.RF_FunSel   = 3'b010;
        bus.RF_RegSel   = 4'b0000;
        bus.RF_ScrSel   = 4'b0000;
        bus.ALU_FunSel  = 5'b00000;
        bus.ALU_WF      = 1'b0;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.ARF_FunSel  = 3'b010;
        bus.ARF_RegSel  = 3'b000;
        bus.IR_LH       = 1'b0;
        bus.IR_Write    = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.Mem_WR      = 1'b0;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
        bus.T           = Reset ? 3'b000 : r_state;
        if (!Reset) begin
            case (r_state)
                S_T0, S_T1: begin
                    bus.ARF_OutCSel = 2'b00;
                    bus.Mem_CS      = 1'b0;
                    bus.IR_Write    = 1'b1;
                    bus.IR_LH       = (r_state == S_T1);
                    bus.ARF_RegSel  = 3'b100;
                    bus.ARF_FunSel  = 3'b001;
                end
                S_T2: begin
                    if (w_take_branch) begin
                        bus.MuxBSel    = 2'b10;
                        bus.ARF_RegSel = 3'b100;
                    end
                    case (w_opcode)
                        6'h04: begin
                            bus.MuxASel   = 2'b10;
                            bus.RF_RegSel = w_rx_onehot;
                        end
                        6'h05: begin
                            bus.MuxBSel    = 2'b10;
                            bus.ARF_RegSel = 3'b010;
                        end
                        6'h06: begin
                            bus.ARF_OutCSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.MuxASel     = 2'b11;
                            bus.RF_RegSel   = w_rx_onehot;
                        end
                        6'h07: begin
                            bus.RF_OutBSel  = {1'b0, w_rx};
                            bus.ALU_FunSel  = 5'b00001;
                            bus.ARF_OutCSel = 2'b10;
                            bus.Mem_CS      = 1'b0;
                            bus.Mem_WR      = 1'b1;
                        end
                        6'h08: begin
                            bus.RF_OutBSel = {1'b0, w_ry};
                            bus.ALU_FunSel = 5'b00001;
                            bus.MuxASel    = 2'b00;
                            bus.RF_RegSel  = w_rx_onehot;
                            bus.ALU_WF     = 1'b1;
                        end
                        6'h09: begin
                            bus.RF_RegSel = w_rx_onehot;
                            bus.RF_FunSel = 3'b001;
                        end
                        6'h0A: begin
                            bus.RF_RegSel = w_rx_onehot;
                            bus.RF_FunSel = 3'b000;
                        end
                        default: ;
                    endcase
                end
                // Pass the updated register through the ALU so flags track it.
                S_T3: begin
                    bus.RF_OutBSel = {1'b0, w_rx};
                    bus.ALU_FunSel = 5'b00001;
                    bus.ALU_WF     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a cycle-count instruction model checked
// every cycle, plus hand-computed literal expectations.
module tb_control_sequencer;
    typedef struct packed {
        logic [2:0] RF_OutASel;
        logic [2:0] RF_OutBSel;
        logic [2:0] RF_FunSel;
        logic [3:0] RF_RegSel;
        logic [3:0] RF_ScrSel;
        logic [4:0] ALU_FunSel;
        logic       ALU_WF;
        logic [1:0] ARF_OutCSel;
        logic [1:0] ARF_OutDSel;
        logic [2:0] ARF_FunSel;
        logic [2:0] ARF_RegSel;
        logic       IR_LH;
        logic       IR_Write;
        logic       Mem_CS;
        logic       Mem_WR;
        logic [1:0] MuxASel;
        logic [1:0] MuxBSel;
        logic       MuxCSel;
        logic [2:0] T;
    } ctrl_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   m_c;
    bit   m_halt;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t dut_out();
        ctrl_t a;
        a = '{bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel,
              bus.RF_ScrSel, bus.ALU_FunSel, bus.ALU_WF, bus.ARF_OutCSel,
              bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel, bus.IR_LH,
              bus.IR_Write, bus.Mem_CS, bus.Mem_WR, bus.MuxASel, bus.MuxBSel,
              bus.MuxCSel, bus.T};
        return a;
    endfunction

    function automatic int latency(logic [5:0] op);
        return (op == 6'h09 || op == 6'h0A) ? 4 : 3;
    endfunction

    // Expected outputs for cycle c (0-based) of the instruction held in ir.
    function automatic ctrl_t model_out(bit r, bit halted, int c, logic [15:0] ir, logic [3:0] fl);
        ctrl_t e;
        logic [5:0] op;
        int rx;
        int ry;
        op = ir[15:10];
        rx = int'(ir[9:8]);
        ry = int'(ir[7:6]);
        e = '0;
        e.RF_FunSel  = 3'b010;
        e.ARF_FunSel = 3'b010;
        e.Mem_CS     = 1'b1;
        if (r) return e;
        if (halted) begin
            e.T = 3'd7;
            return e;
        end
        e.T = 3'(c);
        if (c < 2) begin
            e.Mem_CS     = 1'b0;
            e.IR_Write   = 1'b1;
            e.IR_LH      = (c == 1);
            e.ARF_RegSel = 3'b100;
            e.ARF_FunSel = 3'b001;
        end else if (c == 3) begin
            e.RF_OutBSel = 3'(rx);
            e.ALU_FunSel = 5'd1;
            e.ALU_WF     = 1'b1;
        end else begin
            if (op == 6'd1 || (op == 6'd2 && fl[3]) || (op == 6'd3 && !fl[3])) begin
                e.MuxBSel    = 2'b10;
                e.ARF_RegSel = 3'b100;
            end
            if (op == 6'd4) begin
                e.MuxASel = 2'b10; e.RF_RegSel = 4'(1 << (3 - rx));
            end
            if (op == 6'd5) begin
                e.MuxBSel = 2'b10; e.ARF_RegSel = 3'b010;
            end
            if (op == 6'd6) begin
                e.ARF_OutCSel = 2'b10; e.Mem_CS = 1'b0; e.MuxASel = 2'b11;
                e.RF_RegSel = 4'(1 << (3 - rx));
            end
            if (op == 6'd7) begin
                e.RF_OutBSel = 3'(rx); e.ALU_FunSel = 5'd1; e.ARF_OutCSel = 2'b10;
                e.Mem_CS = 1'b0; e.Mem_WR = 1'b1;
            end
            if (op == 6'd8) begin
                e.RF_OutBSel = 3'(ry); e.ALU_FunSel = 5'd1;
                e.RF_RegSel = 4'(1 << (3 - rx)); e.ALU_WF = 1'b1;
            end
            if (op == 6'd9 || op == 6'd10) begin
                e.RF_RegSel = 4'(1 << (3 - rx));
                e.RF_FunSel = (op == 6'd9) ? 3'b001 : 3'b000;
            end
        end
        return e;
    endfunction

    // Instruction-level progress: count cycles until the opcode's latency elapses.
    always @(posedge clk) begin
        if (rst) begin
            m_c    <= 0;
            m_halt <= 1'b0;
        end else if (!m_halt) begin
            if (m_c == latency(bus.IROut[15:10]) - 1) begin
                m_c <= 0;
                if (bus.IROut[15:10] == 6'h3F) m_halt <= 1'b1;
            end else begin
                m_c <= m_c + 1;
            end
        end
    end

    always @(negedge clk) begin
        ctrl_t exp_v;
        ctrl_t act_v;
        exp_v = model_out(rst, m_halt, m_c, bus.IROut, bus.ALUFlags);
        act_v = dut_out();
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp @%0t: got %h expected %h", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at the start of T0; returns positioned in T2 of this instruction.
    task automatic instr(input logic [15:0] ir, input logic [3:0] fl);
        bus.IROut    = ir;
        bus.ALUFlags = fl;
        step(2);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_c    = 0;
        m_halt = 1'b0;
        rst    = 1'b1;
        bus.IROut    = 16'h0000;
        bus.ALUFlags = 4'h0;
        step(2);
        chk("rst_T", int'(bus.T), 0);
        chk("rst_RF_RegSel", int'(bus.RF_RegSel), 0);
        chk("rst_Mem_CS", int'(bus.Mem_CS), 1);
        chk("rst_ARF_RegSel", int'(bus.ARF_RegSel), 0);
        rst = 1'b0;
        #1;
        chk("t0_T", int'(bus.T), 0);
        chk("t0_Mem_CS", int'(bus.Mem_CS), 0);
        chk("t0_IR_Write", int'(bus.IR_Write), 1);
        chk("t0_ARF_RegSel", int'(bus.ARF_RegSel), 4);
        chk("t0_ARF_FunSel", int'(bus.ARF_FunSel), 1);
        chk("t0_IR_LH", int'(bus.IR_LH), 0);
        step(1);
        chk("t1_T", int'(bus.T), 1);
        chk("t1_IR_LH", int'(bus.IR_LH), 1);
        chk("t1_ARF_FunSel", int'(bus.ARF_FunSel), 1);
        step(1);
        chk("nop_T", int'(bus.T), 2);
        chk("nop_ARF_RegSel", int'(bus.ARF_RegSel), 0);
        step(1);

        instr(16'h11A5, 4'h0);
        chk("ldim_MuxASel", int'(bus.MuxASel), 2);
        chk("ldim_RF_RegSel", int'(bus.RF_RegSel), 4);
        chk("ldim_RF_FunSel", int'(bus.RF_FunSel), 2);
        step(1);
        chk("ldim_next_T", int'(bus.T), 0);

        instr(16'h0840, 4'b1000);
        chk("beq_z1_MuxBSel", int'(bus.MuxBSel), 2);
        chk("beq_z1_ARF_RegSel", int'(bus.ARF_RegSel), 4);
        chk("beq_z1_ARF_FunSel", int'(bus.ARF_FunSel), 2);
        step(1);
        chk("beq_z1_next_T", int'(bus.T), 0);

        instr(16'h0840, 4'b0111);
        chk("beq_z0_ARF_RegSel", int'(bus.ARF_RegSel), 0);
        chk("beq_z0_RF_RegSel", int'(bus.RF_RegSel), 0);
        chk("beq_z0_MuxBSel", int'(bus.MuxBSel), 0);
        step(1);
        chk("beq_z0_next_T", int'(bus.T), 0);

        instr(16'h0C40, 4'h0);
        chk("bne_z0_ARF_RegSel", int'(bus.ARF_RegSel), 4);
        step(1);
        instr(16'h0C40, 4'b1000);
        chk("bne_z1_ARF_RegSel", int'(bus.ARF_RegSel), 0);
        step(1);
        instr(16'h0412, 4'h0);
        chk("bra_MuxBSel", int'(bus.MuxBSel), 2);
        step(1);

        instr(16'h2400, 4'h0);
        chk("inc_T", int'(bus.T), 2);
        chk("inc_RF_FunSel", int'(bus.RF_FunSel), 1);
        chk("inc_RF_RegSel", int'(bus.RF_RegSel), 8);
        step(1);
        chk("inc_t3_T", int'(bus.T), 3);
        chk("inc_t3_OutBSel", int'(bus.RF_OutBSel), 0);
        chk("inc_t3_ALU_WF", int'(bus.ALU_WF), 1);
        chk("inc_t3_RF_RegSel", int'(bus.RF_RegSel), 0);
        step(1);
        chk("inc_next_T", int'(bus.T), 0);

        instr(16'h2940, 4'h0);
        chk("dec_RF_FunSel", int'(bus.RF_FunSel), 0);
        chk("dec_RF_RegSel", int'(bus.RF_RegSel), 4);
        step(1);
        chk("dec_t3_OutBSel", int'(bus.RF_OutBSel), 1);
        step(1);

        instr(16'h1E00, 4'h0);
        chk("st_Mem_CS", int'(bus.Mem_CS), 0);
        chk("st_Mem_WR", int'(bus.Mem_WR), 1);
        chk("st_OutCSel", int'(bus.ARF_OutCSel), 2);
        chk("st_OutBSel", int'(bus.RF_OutBSel), 2);
        chk("st_ALU_FunSel", int'(bus.ALU_FunSel), 1);
        step(1);

        instr(16'h1900, 4'h0);
        chk("ld_MuxASel", int'(bus.MuxASel), 3);
        chk("ld_RF_RegSel", int'(bus.RF_RegSel), 4);
        chk("ld_OutCSel", int'(bus.ARF_OutCSel), 2);
        step(1);

        instr(16'h2340, 4'h0);
        chk("mov_OutBSel", int'(bus.RF_OutBSel), 1);
        chk("mov_RF_RegSel", int'(bus.RF_RegSel), 1);
        chk("mov_ALU_WF", int'(bus.ALU_WF), 1);
        step(1);

        instr(16'h1455, 4'h0);
        chk("ldar_ARF_RegSel", int'(bus.ARF_RegSel), 2);
        chk("ldar_MuxBSel", int'(bus.MuxBSel), 2);
        step(1);

        instr(16'h8000, 4'h0);
        chk("ill_RF_RegSel", int'(bus.RF_RegSel), 0);
        chk("ill_ARF_RegSel", int'(bus.ARF_RegSel), 0);
        chk("ill_Mem_CS", int'(bus.Mem_CS), 1);
        step(1);
        chk("ill_next_T", int'(bus.T), 0);

        instr(16'h11A5, 4'h0);
        rst = 1'b1;
        #1;
        chk("midrst_RF_RegSel", int'(bus.RF_RegSel), 0);
        chk("midrst_T", int'(bus.T), 0);
        step(1);
        rst = 1'b0;
        #1;
        chk("midrst_fetch_Mem_CS", int'(bus.Mem_CS), 0);

        instr(16'hFC00, 4'h0);
        chk("hlt_T2", int'(bus.T), 2);
        step(1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_T", int'(bus.T), 7);
            chk("halt_Mem_CS", int'(bus.Mem_CS), 1);
            step(1);
        end
        rst = 1'b1;
        step(1);
        chk("halt_rst_T", int'(bus.T), 0);
        rst = 1'b0;
        bus.IROut = 16'h0000;
        #1;
        chk("halt_rst_fetch_Mem_CS", int'(bus.Mem_CS), 0);
        step(3);
        chk("after_halt_T", int'(bus.T), 0);
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the ALU-system datapath. It fetches a 16-bit instruction from byte-wide memory in two cycles and decodes it. It then sequences execute micro-steps by driving every datapath control input, using the ALU flags for conditional branches. It is the initiator side of the datapath's control interface.

## Interface
- No parameters.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high.
- IROut  in  16  instruction register contents: [15:10] opcode, [9:8] RX, [7:6] RY, [7:0] ADDR/IMM.
- ALUFlags  in  4  registered ALU flags {Z,C,N,O}.
- RF_OutASel, RF_OutBSel  out  3 each  000..011 select R1..R4.
- RF_FunSel  out  3  000 decrement, 001 increment, 010 load, 011 clear.
- RF_RegSel  out  4  one-hot write enable, bit3=R1..bit0=R4.
- RF_ScrSel  out  4  always 0.
- ALU_FunSel  out  5  00001 selects pass B.
- ALU_WF  out  1  flag write enable.
- ARF_OutCSel, ARF_OutDSel  out  2 each  00 PC, 10 AR, 11 SP.
- ARF_FunSel  out  3  same encoding as RF_FunSel.
- ARF_RegSel  out  3  bit2 PC, bit1 AR, bit0 SP.
- IR_LH  out  1  0 loads the low byte, 1 loads the high byte.
- IR_Write  out  1  IR load enable.
- Mem_CS  out  1  active-low chip select.
- Mem_WR  out  1  1 write, 0 read.
- MuxASel, MuxBSel  out  2 each  00 ALUOut, 01 OutC, 10 IR[7:0], 11 MemOut.
- MuxCSel  out  1  always 0.
- T  out  3  current state index, for debug.

## Operation
- States: T0=000, T1=001, T2=010, T3=011, HALT=111.
- Outputs are combinational from the state, IROut and ALUFlags.
- Idle defaults apply whenever a step does not override them:
  - all RegSel = 0, IR_Write = 0, Mem_CS = 1, Mem_WR = 0, ALU_WF = 0;
  - all selects = 0, all FunSel = 010.
- T0 fetch-low: OutCSel=PC, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=001 (PC++). Next state T1.
- T1 fetch-high: same as T0 with IR_LH=1. Next state T2.
- T2 execute, by opcode:
  - 0x00 NOP: no action.
  - 0x01 BRA: MuxBSel=10, ARF_RegSel=100, ARF_FunSel=010.
  - 0x02 BEQ: as BRA only if Z=1, otherwise no action.
  - 0x03 BNE: as BRA only if Z=0, otherwise no action.
  - 0x04 LDIM: MuxASel=10, RF_RegSel=onehot(RX), RF_FunSel=010.
  - 0x05 LDAR: MuxBSel=10, ARF_RegSel=010, ARF_FunSel=010.
  - 0x06 LD: OutCSel=AR, Mem_CS=0, MuxASel=11, RF load RX.
  - 0x07 ST: OutBSel=RX, ALU_FunSel=00001, OutCSel=AR, Mem_CS=0, Mem_WR=1.
  - 0x08 MOV: OutBSel=RY, ALU_FunSel=00001, MuxASel=00, RF load RX, ALU_WF=1.
  - 0x09 INC: RF_RegSel=onehot(RX), RF_FunSel=001. Next state T3.
  - 0x0A DEC: RF_RegSel=onehot(RX), RF_FunSel=000. Next state T3.
  - 0x3F HLT: no action. Next state HALT.
  - Any other opcode: executes as NOP.
  - Every opcode except INC, DEC and HLT returns to T0.
- T3 (INC/DEC only): OutBSel=RX, ALU_FunSel=00001, ALU_WF=1 so the flags reflect the new RX value. Next state T0.
- HALT: idle defaults; remains in HALT until Reset.
- Branch target is zero-extended IR[7:0]; the PC increments of T0/T1 are overwritten.

## Timing
- Reset sampled high at an edge: state becomes T0.
- While Reset is high, every output is forced to idle defaults and T=000.
- The first fetch starts in the first cycle after Reset deasserts.
- Reset mid-instruction, including in HALT: the instruction is abandoned and no datapath write occurs in the Reset cycles.
- Instruction latency in cycles:
  - 3 for NOP, BRA, BEQ, BNE, LDIM, LDAR, LD, ST, MOV and illegal opcodes;
  - 4 for INC and DEC;
  - HLT halts after 3.
- Memory reads are combinational, so a register load captures MemOut at the same edge.
- ALUFlags written at edge N are valid for a T2 decision in cycle N+1 or later.
- The IR high byte loaded at the end of T1 is visible in T2.

## Test plan
- Reset for 2 cycles, then run: all RegSel=0, Mem_CS=1, T=000 during reset; T sequence is 000, 001, 010 afterwards with PC++ in T0 and T1.
- LDIM with IROut=0x11A5 (RX=01): in T2, MuxASel=10, RF_RegSel=0100, RF_FunSel=010; next state T0.
- BEQ 0x0840: Z=1 gives MuxBSel=10, ARF_RegSel=100 in T2; Z=0 gives all writes 0; both cases return to T0.
- INC with IROut=0x2400 (R1): T2 has RF_FunSel=001, RF_RegSel=1000; T3 has OutBSel=000, ALU_WF=1; 4-cycle total.
- ST with IROut=0x1E00 (RX=R3): in T2, Mem_CS=0, Mem_WR=1, OutCSel=10, OutBSel=010.
- Opcode 0x3F gives HALT held for 10 cycles with no writes; Reset asserted in HALT returns to T0. Opcode 0x20 behaves as NOP.
